alu_pwr_seq: RTL

Power sequencer for the ALU power domain. It turns a single level sleep request into the ordered control sequence the ALU domain requires: drain, save, isolate, power off, then on wake power up, restore and de-isolate. It drives the ALU's `alu_pwr_en`, `iso_en`, `save` and `restore` inputs. It gates `start` so no operation is issued while the domain is unavailable. It sits directly upstream of the ALU instance in `top`, alongside the always-on block, and is itself always-on.

---
 rtl/alu_pwr_pkg.sv | 31 +++
 rtl/alu_pwr_seq_pwr_delay_cnt.sv | 30 +++
 rtl/alu_pwr_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_pwr_pkg.sv
// Shared definitions for the ALU power-domain sequencer: state encoding,
// default delay parameters and small elaboration-time helpers.
package alu_pwr_pkg;

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_SAVE    = 3'd2,
    ST_ISO     = 3'd3,
    ST_OFF     = 3'd4,
    ST_PWRUP   = 3'd5,
    ST_RESTORE = 3'd6,
    ST_UNISO   = 3'd7
  } seq_state_e;

  localparam int ISO_CYCLES_DEF   = 2;
  localparam int PWRUP_CYCLES_DEF = 4;

  // A zero-length hold still has to occupy its state for one cycle.
  function automatic int eff_cycles(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  // Counter holds (max - 1), so $clog2(max) bits suffice; never below 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/alu_pwr_seq_pwr_delay_cnt.sv
// Loadable down-counter shared by the isolation-hold and power-up settle
// phases; done_o is high whenever the count has reached zero.
module pwr_delay_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// Always-on power sequencer for the ALU domain (drain, save, isolate, off,
// power-up, restore, de-isolate). Macro ALU_PWR_RETENTION_EN enables SAVE/RESTORE.
module alu_pwr_seq
  import alu_pwr_pkg::*;
#(
  parameter int ISO_CYCLES   = ISO_CYCLES_DEF,
  parameter int PWRUP_CYCLES = PWRUP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sleep_req,
  input  logic       start_in,
  input  logic       alu_busy,
  output logic       start_out,
  output logic       start_drop,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       alu_ready,
  output logic [2:0] seq_state
);

  localparam int ISO_EFF   = eff_cycles(ISO_CYCLES);
  localparam int PWRUP_EFF = eff_cycles(PWRUP_CYCLES);
  localparam int CW        = cnt_width(ISO_EFF, PWRUP_EFF);
  localparam logic [CW-1:0] ISO_LOAD   = CW'(ISO_EFF - 1);
  localparam logic [CW-1:0] PWRUP_LOAD = CW'(PWRUP_EFF - 1);

  seq_state_e    state_q, state_d;
  logic          idle_q, idle_d;
  logic          cnt_load, cnt_done;
  logic [CW-1:0] cnt_val;

  logic pwr_q, pwr_d, iso_q, iso_d, save_q, save_d;
  logic rest_q, rest_d, rdy_q, rdy_d, drop_q, drop_d;

  pwr_delay_cnt #(.W(CW)) u_dly (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    idle_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = ISO_LOAD;
    case (state_q)
      ST_ON: if (sleep_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // idle_q remembers that the previous DRAIN cycle already saw busy low.
        if (!sleep_req) begin
          state_d = ST_ON;
        end else if (!alu_busy && idle_q) begin
`ifdef ALU_PWR_RETENTION_EN
          state_d  = ST_SAVE;
`else
          state_d  = ST_ISO;
          cnt_load = 1'b1;
`endif
        end else begin
          idle_d = !alu_busy;
        end
      end
`ifdef ALU_PWR_RETENTION_EN
      ST_SAVE: begin
        state_d  = ST_ISO;
        cnt_load = 1'b1;
      end
      ST_RESTORE: state_d = ST_UNISO;
`endif
      ST_ISO: if (cnt_done) state_d = ST_OFF;
      ST_OFF: begin
        if (!sleep_req) begin
          state_d  = ST_PWRUP;
          cnt_load = 1'b1;
          cnt_val  = PWRUP_LOAD;
        end
      end
      ST_PWRUP: begin
`ifdef ALU_PWR_RETENTION_EN
        if (cnt_done) state_d = ST_RESTORE;
`else
        if (cnt_done) state_d = ST_UNISO;
`endif
      end
      ST_UNISO: state_d = ST_ON;
      default:  state_d = ST_ON;
    endcase
  end

  // Outputs are decoded from the next state so they change on the entering edge.
  always_comb begin
    pwr_d  = (state_d != ST_OFF);
    iso_d  = (state_d inside {ST_ISO, ST_OFF, ST_PWRUP, ST_RESTORE});
`ifdef ALU_PWR_RETENTION_EN
    save_d = (state_d == ST_SAVE);
    rest_d = (state_d == ST_RESTORE);
`else
    save_d = 1'b0;
    rest_d = 1'b0;
`endif
    rdy_d  = (state_d == ST_ON);
    drop_d = start_in && (state_q != ST_ON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ON;
      idle_q  <= 1'b0;
      pwr_q   <= 1'b1;
      iso_q   <= 1'b0;
      save_q  <= 1'b0;
      rest_q  <= 1'b0;
      rdy_q   <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      pwr_q   <= pwr_d;
      iso_q   <= iso_d;
      save_q  <= save_d;
      rest_q  <= rest_d;
      rdy_q   <= rdy_d;
      drop_q  <= drop_d;
    end
  end

  assign start_out  = start_in && (state_q == ST_ON);
  assign start_drop = drop_q;
  assign alu_pwr_en = pwr_q;
  assign iso_en     = iso_q;
  assign save       = save_q;
  assign restore    = rest_q;
  assign alu_ready  = rdy_q;
  assign seq_state  = state_q;

endmodule
